fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/mips_pkg.sv | 25 ++
 rtl/next_pc.sv | 45 ++++
 rtl/fetch_unit.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch unit and its next-PC helper.
package mips_pkg;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2,
      ST_HALT  = 2'd3
   } fetch_state_e;

   typedef enum logic [1:0] {
      NPC_SEQ    = 2'd0,
      NPC_BRANCH = 2'd1,
      NPC_JUMP   = 2'd2,
      NPC_JR     = 2'd3
   } npc_sel_e;

   // Word offset to byte offset, sign-extended to the full address width.
   function automatic logic [31:0] branch_offset(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/next_pc.sv
// Combinational next-PC selection: jr, j, bltz-taken or sequential, all modulo 2^32.
module next_pc
   import mips_pkg::*;
(
   input  logic [31:0] pc_i,
   input  logic        jump_i,
   input  logic        branch_i,
   input  logic [25:0] target_inst_i,
   input  logic [31:0] jr_addr_i,
   input  logic        rs_neg_i,
   input  logic [15:0] imm16_i,
   output logic [31:0] next_pc_o
);

   logic [31:0] pc4_s;
   npc_sel_e    sel_s;

   assign pc4_s = pc_i + 32'd4;

   always_comb begin
      sel_s = NPC_SEQ;
      if (jump_i && branch_i) begin
         sel_s = NPC_JR;
      end else if (jump_i) begin
         sel_s = NPC_JUMP;
      end else if (branch_i && rs_neg_i) begin
         sel_s = NPC_BRANCH;
      end else begin
         sel_s = NPC_SEQ;
      end
   end

   // Register targets are always word-aligned here; misaligned jr is trapped upstream when checked.
   always_comb begin
      next_pc_o = pc4_s;
      case (sel_s)
         NPC_JR:     next_pc_o = jr_addr_i & 32'hFFFF_FFFC;
         NPC_JUMP:   next_pc_o = {pc4_s[31:28], target_inst_i, 2'b00};
         NPC_BRANCH: next_pc_o = pc4_s + branch_offset(imm16_i);
         NPC_SEQ:    next_pc_o = pc4_s;
         default:    next_pc_o = pc4_s;
      endcase
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch FSM (IDLE/FETCH/EXEC/HALT) with registered outputs.
// Define FETCH_ALIGN_CHECK_EN to trap misaligned jr targets into a reset-only HALT.
module fetch_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        jump,
   input  logic        branch,
   input  logic [25:0] target_inst,
   input  logic [31:0] jr_addr,
   input  logic        rs_neg,
   input  logic [15:0] imm16,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instruction,
   output logic        inst_valid,
   output logic [31:0] pc,
   output logic        fault
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  instr_q, instr_d;
   logic         imem_req_q, imem_req_d;
   logic         inst_valid_q, inst_valid_d;
   logic         fault_q, fault_d;
   logic [31:0]  npc_s;
   logic         jr_misaligned_s;

   next_pc u_next_pc (
      .pc_i          (pc_q),
      .jump_i        (jump),
      .branch_i      (branch),
      .target_inst_i (target_inst),
      .jr_addr_i     (jr_addr),
      .rs_neg_i      (rs_neg),
      .imm16_i       (imm16),
      .next_pc_o     (npc_s)
   );

`ifdef FETCH_ALIGN_CHECK_EN
   assign jr_misaligned_s = jump & branch & (jr_addr[1:0] != 2'b00);
`else
   assign jr_misaligned_s = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  state_d = ST_FETCH;
         ST_FETCH: begin
            if (imem_ack) state_d = ST_EXEC;
            else          state_d = ST_FETCH;
         end
         ST_EXEC: begin
            if (jr_misaligned_s) state_d = ST_HALT;
            else                 state_d = ST_FETCH;
         end
         ST_HALT:  state_d = ST_HALT;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Outputs are computed from the next state so they are registered yet aligned with it.
   always_comb begin
      imem_req_d   = (state_d == ST_FETCH);
      inst_valid_d = (state_d == ST_EXEC);
`ifdef FETCH_ALIGN_CHECK_EN
      fault_d      = (state_d == ST_HALT);
`else
      fault_d      = 1'b0;
`endif
      pc_d    = pc_q;
      instr_d = instr_q;
      if ((state_q == ST_EXEC) && (state_d == ST_FETCH)) begin
         pc_d = npc_s;
      end else begin
         pc_d = pc_q;
      end
      if ((state_q == ST_FETCH) && imem_ack) begin
         instr_d = imem_rdata;
      end else begin
         instr_d = instr_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q         <= RESET_PC;
         instr_q      <= 32'h0000_0000;
         imem_req_q   <= 1'b0;
         inst_valid_q <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         instr_q      <= instr_d;
         imem_req_q   <= imem_req_d;
         inst_valid_q <= inst_valid_d;
         fault_q      <= fault_d;
      end
   end

   assign imem_req    = imem_req_q;
   assign imem_addr   = pc_q;
   assign instruction = instr_q;
   assign inst_valid  = inst_valid_q;
   assign pc          = pc_q;
   assign fault       = fault_q;

endmodule
